graphics_datapath: RTL
======================

// Module: graphics_datapath
// PURPOSE
//  Datapath fed by the graphics control FSM: turns its load/draw strobes into VGA pixel writes.
//  Holds the current tile and colour, and scans an 8x8 pixel block inside a 2x2 tile grid.
//  Generates pseudo-random tiles with an LFSR and records each random pick in a sequence buffer.
//  The player-input checker reads that buffer later; x/y/colour/plot drive the VGA adapter.
// PARAMETERS
//  X0       8'd64   x pixel of tile 0 top-left corner
//  Y0       7'd48   y pixel of tile 0 top-left corner
//  PITCH    8'd10   spacing between tile origins, x and y (tile is 8 px wide, gap 2)
//  SEED     8'hA5   LFSR reset value; must be nonzero
//  SEQ_DEPTH 16     sequence buffer entries (power of 2, >= 9)
// PORTS
//  clock          in   1  system clock, all state on rising edge
//  reset          in   1  synchronous, active-high
//  ld_tile        in   1  load tile index and base colour; clear pixel count
//  random_enable  in   1  advance LFSR; with ld_tile, tile comes from LFSR, not tile_num
//  tile_num       in   2  tile index used by ld_tile when random_enable=0
//  ld_flash       in   1  load flash colour for the held tile; clear pixel count
//  ld_previous    in   1  reload base colour of the held tile; clear pixel count
//  write_enable   in   1  emit one pixel this cycle
//  counter_enable in   1  advance pixel count
//  clear_seq      in   1  empty the sequence buffer
//  rd_addr        in   4  sequence buffer read index
//  x              out  8  pixel x (registered)
//  y              out  7  pixel y (registered)
//  colour         out  3  pixel colour {R,G,B} (registered)
//  plot           out  1  VGA write strobe (registered)
//  cur_tile       out  2  held tile index
//  rd_tile        out  2  sequence buffer entry at rd_addr (registered, 1-cycle latency)
//  seq_len        out  5  number of valid buffer entries, 0..16
//  seq_full       out  1  seq_len == SEQ_DEPTH
// BEHAVIOUR
//  Reset values:
//   - x=X0, y=Y0, colour=0, plot=0, cur_tile=0, rd_tile=0, seq_len=0, seq_full=0
//   - pixel count=0, LFSR=SEED, held colour=0
//  Base colours: tile0 3'b100, tile1 3'b010, tile2 3'b001, tile3 3'b110. Flash colour 3'b111.
//  Tile origin: ox = X0 + PITCH*tile[0], oy = Y0 + PITCH*tile[1]. 8-bit wrap, no saturation.
//  Load priority: ld_tile > ld_flash > ld_previous. Any load clears the 6-bit pixel count cnt.
//   - ld_tile: cur_tile <= random_enable ? lfsr[1:0] : tile_num; held colour <= base(new tile).
//   - ld_flash: held colour <= 3'b111.
//   - ld_previous: held colour <= base(cur_tile).
//  Pixel scan, used when write_enable=1 and no load is active:
//   - Next cycle: x <= ox + cnt[2:0], y <= oy + cnt[5:3], colour <= held colour, plot <= 1.
//   - Otherwise plot <= 0 next cycle; x/y/colour hold their values.
//  Pixel count:
//   - counter_enable and no load: cnt <= cnt + 1. Wraps 63 -> 0.
//   - The control FSM produces 64 strobes per tile, so the final pixel is cnt=63.
//  The pixel output uses cnt before the increment, so pixel k appears 1 cycle after its strobe.
//  LFSR:
//   - 8-bit Fibonacci, taps 8,6,5,4; shift left, feedback into bit 0.
//   - Advances every cycle random_enable=1.
//   - ld_tile with random_enable samples the pre-advance value.
//  Sequence buffer:
//   - Random append: ld_tile & random_enable writes the new tile at index seq_len and increments seq_len.
//   - Full buffer: when seq_full=1 the append is dropped and seq_len holds.
//   - clear_seq: seq_len <= 0 and seq_full <= 0. Contents are not erased.
//   - clear_seq with an append in the same cycle: clear wins, append dropped.
//   - Read: rd_tile <= mem[rd_addr] every cycle. Entries at index >= seq_len return stale data.
//   - Write and read of the same index in one cycle: read returns the old value.
//  Reset mid-scan: all state returns to reset values next cycle; plot=0 from that cycle onward.
// TESTING
//  1. Assert reset 2 cycles, release -> x=64, y=48, plot=0, seq_len=0, colour=0.
//  2. Pulse ld_tile with tile_num=3, then 64 cycles of write/counter_enable
//     -> 64 plots, first (74,58,3'b110), last (81,65,3'b110); plot=0 on the cycle after.
//  3. After test 2, pulse ld_flash, draw 64, then ld_previous, draw 64
//     -> colour 3'b111 on the first pass, 3'b110 on the second; cur_tile stays 3.
//  4. From reset, 17 cycles of ld_tile+random_enable
//     -> cur_tile = LFSR[1:0] sequence from SEED 8'hA5, first pick 2'b01; seq_len=16, seq_full=1, 17th pick dropped.
//  5. Read rd_addr 0..15 after test 4 -> rd_tile matches logged picks, 1-cycle latency.
//     Then clear_seq with an append in the same cycle -> seq_len=0.
//  6. Assert reset on pixel 20 of a scan -> next cycle plot=0, x=64, y=48;
//     a following ld_tile tile 0 scan starts at cnt=0.

Source files
------------

// File: rtl/graphics_datapath.sv
// Graphics datapath: tile/colour hold, 8x8 pixel scan,
// LFSR tile picker and random-sequence buffer.
module graphics_datapath #(
  parameter logic [7:0] X0        = 8'd64,
  parameter logic [6:0] Y0        = 7'd48,
  parameter logic [7:0] PITCH     = 8'd10,
  parameter logic [7:0] SEED      = 8'hA5,
  parameter int         SEQ_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ld_tile,
  input  logic       random_enable,
  input  logic [1:0] tile_num,
  input  logic       ld_flash,
  input  logic       ld_previous,
  input  logic       write_enable,
  input  logic       counter_enable,
  input  logic       clear_seq,
  input  logic [3:0] rd_addr,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic [1:0] cur_tile,
  output logic [1:0] rd_tile,
  output logic [4:0] seq_len,
  output logic       seq_full
);

  logic [5:0] cnt;
  logic [7:0] lfsr;
  logic [2:0] held;
  logic [1:0] mem [SEQ_DEPTH];
  logic       load;
  logic [1:0] new_tile;
  logic       append;
  logic       fb;
  logic [7:0] ox;
  logic [6:0] oy;

  function automatic logic [2:0] base(input logic [1:0] t);
    logic [2:0] c;
    c = 3'b100;
    unique case (t)
      2'd0: c = 3'b100;
      2'd1: c = 3'b010;
      2'd2: c = 3'b001;
      2'd3: c = 3'b110;
    endcase
    return c;
  endfunction

  assign load     = ld_tile | ld_flash | ld_previous;
  assign new_tile = random_enable ? lfsr[1:0] : tile_num;
  assign seq_full = (seq_len == 5'(SEQ_DEPTH));
  assign append   = ld_tile & random_enable
                  & ~seq_full & ~clear_seq;
  assign fb       = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign ox = X0 + (cur_tile[0] ? PITCH : 8'd0);
  assign oy = Y0 + (cur_tile[1] ? PITCH[6:0] : 7'd0);

  // held tile and colour, loads in priority order
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_tile <= 2'd0;
      held     <= 3'd0;
    end else if (ld_tile) begin
      cur_tile <= new_tile;
      held     <= base(new_tile);
    end else if (ld_flash) begin
      held <= 3'b111;
    end else if (ld_previous) begin
      held <= base(cur_tile);
    end
  end

  // pixel counter, cleared by any load
  always_ff @(posedge clock) begin
    if (reset)               cnt <= 6'd0;
    else if (load)           cnt <= 6'd0;
    else if (counter_enable) cnt <= cnt + 6'd1;
  end

  // registered pixel output from the pre-increment count
  always_ff @(posedge clock) begin
    if (reset) begin
      x      <= X0;
      y      <= Y0;
      colour <= 3'd0;
      plot   <= 1'b0;
    end else if (write_enable && !load) begin
      x      <= ox + {5'd0, cnt[2:0]};
      y      <= oy + {4'd0, cnt[5:3]};
      colour <= held;
      plot   <= 1'b1;
    end else begin
      plot <= 1'b0;
    end
  end

  // LFSR advances whenever random mode is on
  always_ff @(posedge clock) begin
    if (reset)              lfsr <= SEED;
    else if (random_enable) lfsr <= {lfsr[6:0], fb};
  end

  // sequence length; clear beats a same-cycle append
  always_ff @(posedge clock) begin
    if (reset)          seq_len <= 5'd0;
    else if (clear_seq) seq_len <= 5'd0;
    else if (append)    seq_len <= seq_len + 5'd1;
  end

  // buffer storage keeps contents across reset and clear
  always_ff @(posedge clock) begin
    if (append) mem[seq_len[3:0]] <= new_tile;
  end

  // synchronous read, old data on same-index write
  always_ff @(posedge clock) begin
    if (reset) rd_tile <= 2'd0;
    else       rd_tile <= mem[rd_addr];
  end

endmodule
